// File: rtl/dmem_pkg.sv
// Shared types and helpers for the synchronous MEM-stage data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // Byte-lane enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Access is illegal: unaligned half/word, or the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed byte/halfword from a memory word and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select followed by sign or zero extension; words pass through.
    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = word[{offset[1], 4'b0000} +: 16];
        data   = word;
        case (size)
            SZ_BYTE: data = {{24{~unsigned_ld & lane_b[7]}}, lane_b};
            SZ_HALF: data = {{16{~unsigned_ld & lane_h[15]}}, lane_h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory with byte lanes, sized loads, fault detection and
// a post-reset clear sequencer. Loads return two edges after acceptance.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        ready
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    logic [AW-1:0] idx;
    logic [1:0]    offset;
    logic          fault;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic          store_go, load_go, fault_go;

    // Request captured at acceptance; the array is read on the following edge.
    logic          ld_q, flt_q;
    logic [AW-1:0] ld_idx_q;
    logic [1:0]    ld_off_q, ld_size_q;
    logic          ld_uns_q;
    logic [31:0]   ld_data;

    logic          unused_addr;

    assign idx         = address[AW+1:2];
    assign offset      = address[1:0];
    assign unused_addr = ^address[31:AW+2];

    assign ready    = (state_q == ST_RUN);
    assign fault    = is_misaligned(size, offset);
    assign be       = byte_enable(size, offset);
    assign store_go = ready & memwrite & ~fault;
    assign load_go  = ready & memread & ~memwrite & ~fault;
    assign fault_go = ready & (memread | memwrite) & fault;

    // Store data replicated across lanes so the byte enables pick the right copy.
    always_comb begin
        wlanes = writedata;
        case (size)
            SZ_BYTE: wlanes = {4{writedata[7:0]}};
            SZ_HALF: wlanes = {2{writedata[15:0]}};
            default: wlanes = writedata;
        endcase
    end

    // Clear sequencer next state: sweep every word once, then serve requests.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            default: state_d = state_q;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array writes: clear sweep or lane-masked store; blocked while in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (store_go) begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mem[idx][8*k +: 8] <= wlanes[8*k +: 8];
                end
            end
        end
    end

    // Request stage: remember accepted loads and faults for the response edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q      <= 1'b0;
            flt_q     <= 1'b0;
            ld_idx_q  <= '0;
            ld_off_q  <= '0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
        end else begin
            ld_q  <= load_go;
            flt_q <= fault_go;
            if (load_go) begin
                ld_idx_q  <= idx;
                ld_off_q  <= offset;
                ld_size_q <= size;
                ld_uns_q  <= unsigned_ld;
            end
        end
    end

    dmem_load_align u_align (
        .word        (mem[ld_idx_q]),
        .offset      (ld_off_q),
        .size        (ld_size_q),
        .unsigned_ld (ld_uns_q),
        .data        (ld_data)
    );

    // Response stage: readdata only moves when a load completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata    <= '0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            rdata_valid <= ld_q;
            misalign    <= flt_q;
            if (ld_q) readdata <= ld_data;
        end
    end

endmodule

// File: tb/tb_dmem_sync.sv
// Self-checking bench for dmem_sync: directed cases plus randomized traffic
// checked every cycle against a behavioural array model.
module tb_dmem_sync;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, memread, memwrite, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] address, writedata, readdata;
    logic        rdata_valid, misalign, ready;

    always #5 clk = ~clk;

    dmem_sync #(
        .DEPTH      (DEPTH),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memread     (memread),
        .memwrite    (memwrite),
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .ready       (ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state.
    int unsigned m_mem [DEPTH];
    bit          m_run;
    int          m_cnt;
    bit          p_ld, p_flt, p_uns;
    int unsigned p_addr;
    bit [1:0]    p_size;
    bit          e_valid, e_mis;
    int unsigned e_rd;

    function automatic bit faults(input int unsigned a, input bit [1:0] sz);
        return (sz == 3) || (sz == 1 && a % 2 == 1) || (sz == 2 && a % 4 != 0);
    endfunction

    function automatic int unsigned load_val(input int unsigned w, input int unsigned a,
                                             input bit [1:0] sz, input bit uns);
        int unsigned v;
        if (sz == 2) return w;
        if (sz == 0) begin
            v = (w >> (8 * (a % 4))) % 256;
            if (!uns && v >= 128) v += 32'hFFFFFF00;
        end else begin
            v = (w >> (16 * ((a / 2) % 2))) % 65536;
            if (!uns && v >= 32768) v += 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic int unsigned store_val(input int unsigned w, input int unsigned a,
                                              input bit [1:0] sz, input int unsigned d);
        int unsigned sh, mask;
        if (sz == 2) return d;
        if (sz == 0) begin
            sh   = 8 * (a % 4);
            mask = 32'd255 << sh;
            return (w & ~mask) | ((d % 256) << sh);
        end
        sh   = 16 * ((a / 2) % 2);
        mask = 32'd65535 << sh;
        return (w & ~mask) | ((d % 65536) << sh);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        if (reset) begin
            m_run = 0; m_cnt = 0; p_ld = 0; p_flt = 0;
            e_valid = 0; e_mis = 0; e_rd = 0;
        end else begin
            e_valid = p_ld;
            e_mis   = p_flt;
            if (p_ld) e_rd = load_val(m_mem[(p_addr / 4) % DEPTH], p_addr, p_size, p_uns);
            p_ld  = 0;
            p_flt = 0;
            if (!m_run) begin
                m_mem[m_cnt] = 0;
                m_cnt++;
                if (m_cnt == DEPTH) m_run = 1;
            end else if (memread || memwrite) begin
                if (faults(address, size)) begin
                    p_flt = 1;
                end else if (memwrite) begin
                    m_mem[(address / 4) % DEPTH] =
                        store_val(m_mem[(address / 4) % DEPTH], address, size, writedata);
                end else begin
                    p_ld = 1; p_addr = address; p_size = size; p_uns = unsigned_ld;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ready",       {31'b0, ready},       {31'b0, m_run});
        check_eq("rdata_valid", {31'b0, rdata_valid}, {31'b0, e_valid});
        check_eq("misalign",    {31'b0, misalign},    {31'b0, e_mis});
        check_eq("readdata",    readdata,             e_rd);
    endtask

    task automatic set_req(input bit rd, input bit wr, input bit [1:0] sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] d);
        memread = rd; memwrite = wr; size = sz; unsigned_ld = uns;
        address = a; writedata = d;
    endtask

    task automatic idle();
        memread = 1'b0; memwrite = 1'b0;
    endtask

    task automatic req(input bit rd, input bit wr, input bit [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] d);
        set_req(rd, wr, sz, uns, a, d);
        step();
        idle();
    endtask

    // Load, then check the response against a fixed expected value.
    task automatic ld(input string tag, input bit [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] exp);
        req(1'b1, 1'b0, sz, uns, a, 32'h0);
        step();
        check_eq({tag, "_valid"}, {31'b0, rdata_valid}, 32'd1);
        check_eq(tag, readdata, exp);
    endtask

    task automatic mis(input string tag, input bit rd, input bit wr, input bit [1:0] sz,
                       input logic [31:0] a);
        req(rd, wr, sz, 1'b0, a, 32'hFFFF_FFFF);
        step();
        check_eq({tag, "_mis"},   {31'b0, misalign},    32'd1);
        check_eq({tag, "_valid"}, {31'b0, rdata_valid}, 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 100) begin
            step();
            n++;
        end
        check_eq(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        reset = 1'b1;
        set_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
        step();
        check_eq("rst_ready", {31'b0, ready}, 32'd0);
        reset = 1'b0;
        wait_ready("ready_rise");

        for (int a = 0; a < DEPTH; a++) ld("lw_zero", 2'b10, 1'b0, 32'(a * 4), 32'h0);

        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
        ld("lb_10",  2'b00, 1'b0, 32'h10, 32'hFFFFFFBB);
        ld("lb_11",  2'b00, 1'b0, 32'h11, 32'hFFFFFFAA);
        ld("lb_13",  2'b00, 1'b0, 32'h13, 32'hFFFFFF88);
        ld("lbu_13", 2'b00, 1'b1, 32'h13, 32'h00000088);
        ld("lh_12",  2'b01, 1'b0, 32'h12, 32'hFFFF8899);
        ld("lhu_10", 2'b01, 1'b1, 32'h10, 32'h0000AABB);

        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF55);
        ld("sb_11", 2'b10, 1'b0, 32'h10, 32'h889955BB);
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234);
        ld("sh_12", 2'b10, 1'b0, 32'h10, 32'h123455BB);

        mis("lw_12",  1'b1, 1'b0, 2'b10, 32'h12);
        mis("sh_11",  1'b0, 1'b1, 2'b01, 32'h11);
        mis("rsv_00", 1'b1, 1'b0, 2'b11, 32'h00);
        check_eq("mis_hold", readdata, 32'h123455BB);
        ld("mis_mem", 2'b10, 1'b0, 32'h10, 32'h123455BB);

        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        ld("wrap", 2'b10, 1'b0, 32'h00, 32'hCAFEF00D);

        set_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h13579BDF);
        step();
        set_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        step();
        idle();
        step();
        check_eq("raw_valid", {31'b0, rdata_valid}, 32'd1);
        check_eq("raw_data",  readdata, 32'h13579BDF);

        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'hDEADBEEF);
        step();
        check_eq("rdwr_valid", {31'b0, rdata_valid}, 32'd0);
        ld("rdwr_mem", 2'b10, 1'b0, 32'h24, 32'hDEADBEEF);

        // Reset between acceptance and response.
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        reset = 1'b1;
        step();
        check_eq("midld_valid", {31'b0, rdata_valid}, 32'd0);
        check_eq("midld_data",  readdata, 32'h0);
        reset = 1'b0;
        wait_ready("ready_midld");

        // Reset partway through the clear sweep.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_ready("ready_midclr");
        ld("clr_zero", 2'b10, 1'b0, 32'h24, 32'h0);

        // Random traffic, including a reset and requests during the clear sweep.
        for (int i = 0; i < 600; i++) begin
            reset = (i == 300 || i == 301);
            set_req(1'(($urandom % 4) != 0), 1'($urandom % 2), 2'($urandom % 4),
                    1'($urandom % 2), 32'($urandom_range(0, 255)), $urandom);
            step();
        end
        reset = 1'b0;
        idle();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
